// File: rtl/ccr_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ccr_pkg : CCR field widths, flag bit positions and the parity helper    |
// |           shared by the CCR and its context-save stack.                 |
// | Option  : CCR_STACK_PARITY_EN widens each saved entry by a parity bit.  |
// | Rev 1.0 : initial release                                               |
// +--------------------------------------------------------------------------+
package ccr_pkg;

  localparam int CCR_W = 4;
  localparam int CCR_Z = 0;
  localparam int CCR_N = 1;
  localparam int CCR_C = 2;
  localparam int CCR_V = 3;

`ifdef CCR_STACK_PARITY_EN
  localparam int ENTRY_W = CCR_W + 1;
`else
  localparam int ENTRY_W = CCR_W;
`endif

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic ccr_parity(input logic [CCR_W-1:0] flags);
    return flags[CCR_Z] ^ flags[CCR_N] ^ flags[CCR_C] ^ flags[CCR_V];
  endfunction

endpackage : ccr_pkg
`default_nettype wire

// File: rtl/ccr_stack_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ccr_stack_mem : DEPTH x WIDTH register array, one synchronous write     |
// |                 port and one combinational read port.                   |
// | Rev 1.0 : initial release                                               |
// +--------------------------------------------------------------------------+
module ccr_stack_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  // Contents are don't-care after reset, so the array carries no reset.
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule : ccr_stack_mem
`default_nettype wire

// File: rtl/ccr_save_stack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ccr_save_stack : LIFO that saves CCR flags on interrupt entry and       |
// |                  restores them on RTI through a one-cycle strobe.       |
// | Option  : CCR_STACK_PARITY_EN adds par_inject / par_err and a stored    |
// |           parity bit per entry.                                         |
// | Rev 1.0 : initial release                                               |
// +--------------------------------------------------------------------------+
module ccr_save_stack
  import ccr_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CCR_W-1:0] ccr_in,
  input  logic             push,
  input  logic             pop,
  input  logic             err_clr,
  output logic [CCR_W-1:0] restore_flags,
  output logic             restore_en,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty,
  output logic             ovf_err,
  output logic             unf_err
`ifdef CCR_STACK_PARITY_EN
  ,
  input  logic             par_inject,
  output logic             par_err
`endif
);

  localparam logic [AW:0] c_level_max = (AW+1)'(DEPTH);

  logic [AW:0]        r_level;
  logic [CCR_W-1:0]   r_restore_flags;
  logic               r_restore_en;
  logic               r_ovf_err;
  logic               r_unf_err;

  logic               w_pop_ok;
  logic               w_replace;
  logic               w_push_new;
  logic               w_we;
  logic [AW-1:0]      w_top_addr;
  logic [AW-1:0]      w_waddr;
  logic [ENTRY_W-1:0] w_wdata;
  logic [ENTRY_W-1:0] w_rdata;
  logic               w_ovf_set;
  logic               w_unf_set;

  assign full  = (r_level == c_level_max);
  assign empty = (r_level == '0);

  // Push+pop on a non-empty stack overwrites the top in place after reading it.
  assign w_pop_ok   = pop & ~empty;
  assign w_replace  = push & w_pop_ok;
  assign w_push_new = push & ~full & ~w_pop_ok;
  assign w_we       = w_replace | w_push_new;
  assign w_ovf_set  = push & ~pop & full;
  assign w_unf_set  = pop & empty;

  assign w_top_addr = r_level[AW-1:0] - 1'b1;
  assign w_waddr    = w_replace ? w_top_addr : r_level[AW-1:0];

`ifdef CCR_STACK_PARITY_EN
  assign w_wdata = {ccr_parity(ccr_in) ^ par_inject, ccr_in};
`else
  assign w_wdata = ccr_in;
`endif

  ccr_stack_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_mem (
    .clk   (clk),
    .we    (w_we),
    .waddr (w_waddr),
    .wdata (w_wdata),
    .raddr (w_top_addr),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= '0;
    end else if (w_push_new) begin
      r_level <= r_level + 1'b1;
    end else if (w_pop_ok && !push) begin
      r_level <= r_level - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_restore_flags <= '0;
      r_restore_en    <= 1'b0;
    end else begin
      r_restore_en <= w_pop_ok;
      if (w_pop_ok) begin
        r_restore_flags <= w_rdata[CCR_W-1:0];
      end
    end
  end

  // Sticky errors: a new event in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf_err <= 1'b0;
      r_unf_err <= 1'b0;
    end else begin
      if (w_ovf_set) begin
        r_ovf_err <= 1'b1;
      end else if (err_clr) begin
        r_ovf_err <= 1'b0;
      end
      if (w_unf_set) begin
        r_unf_err <= 1'b1;
      end else if (err_clr) begin
        r_unf_err <= 1'b0;
      end
    end
  end

`ifdef CCR_STACK_PARITY_EN
  logic r_par_err;
  logic w_par_set;

  // Checked on the read, so the flag rises together with restore_en.
  assign w_par_set = w_pop_ok & (w_rdata[CCR_W] != ccr_parity(w_rdata[CCR_W-1:0]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par_err <= 1'b0;
    end else if (w_par_set) begin
      r_par_err <= 1'b1;
    end else if (err_clr) begin
      r_par_err <= 1'b0;
    end
  end

  assign par_err = r_par_err;
`endif

  assign level         = r_level;
  assign restore_flags = r_restore_flags;
  assign restore_en    = r_restore_en;
  assign ovf_err       = r_ovf_err;
  assign unf_err       = r_unf_err;

endmodule : ccr_save_stack
`default_nettype wire

// File: tb/tb_ccr_save_stack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ccr_save_stack : directed self-checking bench for ccr_save_stack.    |
// | Rev 1.0 : initial release                                               |
// +--------------------------------------------------------------------------+
module tb_ccr_save_stack;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] ccr_in = 4'b0000;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic       err_clr = 1'b0;
  logic [3:0] restore_flags;
  logic       restore_en;
  logic [2:0] level;
  logic       full;
  logic       empty;
  logic       ovf_err;
  logic       unf_err;
`ifdef CCR_STACK_PARITY_EN
  logic       par_inject = 1'b0;
  logic       par_err;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  ccr_save_stack #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .ccr_in        (ccr_in),
    .push          (push),
    .pop           (pop),
    .err_clr       (err_clr),
    .restore_flags (restore_flags),
    .restore_en    (restore_en),
    .level         (level),
    .full          (full),
    .empty         (empty),
    .ovf_err       (ovf_err),
    .unf_err       (unf_err)
`ifdef CCR_STACK_PARITY_EN
    ,
    .par_inject    (par_inject),
    .par_err       (par_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic p_push, input logic p_pop, input logic [3:0] d);
    push   = p_push;
    pop    = p_pop;
    ccr_in = d;
    tick();
    push = 1'b0;
    pop  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    if (restore_flags !== 4'b0000) begin $display("FAIL rst_flags got=%b exp=0000", restore_flags); n_fail++; end n_cmp++;
    if (restore_en !== 1'b0) begin $display("FAIL rst_en got=%b exp=0", restore_en); n_fail++; end n_cmp++;
    if (level !== 3'd0) begin $display("FAIL rst_level got=%0d exp=0", level); n_fail++; end n_cmp++;
    if (empty !== 1'b1 || full !== 1'b0) begin $display("FAIL rst_empty_full got=%b%b exp=10", empty, full); n_fail++; end n_cmp++;
    if (ovf_err !== 1'b0 || unf_err !== 1'b0) begin $display("FAIL rst_err got=%b%b exp=00", ovf_err, unf_err); n_fail++; end n_cmp++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_push_pop();
    cyc(1, 0, 4'b0101);
    if (level !== 3'd1) begin $display("FAIL pp_level1 got=%0d exp=1", level); n_fail++; end n_cmp++;
    if (restore_en !== 1'b0) begin $display("FAIL pp_push_no_en got=%b exp=0", restore_en); n_fail++; end n_cmp++;
    cyc(1, 0, 4'b1010);
    if (level !== 3'd2) begin $display("FAIL pp_level2 got=%0d exp=2", level); n_fail++; end n_cmp++;
    cyc(0, 1, 4'b0000);
    if (restore_en !== 1'b1 || restore_flags !== 4'b1010) begin $display("FAIL pp_pop1 got=%b/%b exp=1/1010", restore_en, restore_flags); n_fail++; end n_cmp++;
    if (level !== 3'd1) begin $display("FAIL pp_level_after_pop1 got=%0d exp=1", level); n_fail++; end n_cmp++;
    cyc(0, 0, 4'b0000);
    if (restore_en !== 1'b0 || restore_flags !== 4'b1010) begin $display("FAIL pp_idle_hold got=%b/%b exp=0/1010", restore_en, restore_flags); n_fail++; end n_cmp++;
    cyc(0, 1, 4'b0000);
    if (restore_en !== 1'b1 || restore_flags !== 4'b0101) begin $display("FAIL pp_pop2 got=%b/%b exp=1/0101", restore_en, restore_flags); n_fail++; end n_cmp++;
    if (level !== 3'd0 || empty !== 1'b1) begin $display("FAIL pp_level0 got=%0d/%b exp=0/1", level, empty); n_fail++; end n_cmp++;
    cyc(0, 0, 4'b0000);
    if (restore_en !== 1'b0) begin $display("FAIL pp_en_one_cycle got=%b exp=0", restore_en); n_fail++; end n_cmp++;
  endtask

  task automatic test_overflow();
    logic [3:0] exp_v;
    for (int i = 1; i <= 5; i++) begin
      cyc(1, 0, 4'(i));
      if (i == 4 && ovf_err !== 1'b0) begin $display("FAIL ovf_early got=%b exp=0", ovf_err); n_fail++; end
      if (i == 4) n_cmp++;
    end
    if (level !== 3'd4 || full !== 1'b1) begin $display("FAIL ovf_level_full got=%0d/%b exp=4/1", level, full); n_fail++; end n_cmp++;
    if (ovf_err !== 1'b1) begin $display("FAIL ovf_flag got=%b exp=1", ovf_err); n_fail++; end n_cmp++;
    for (int i = 4; i >= 1; i--) begin
      exp_v = 4'(i);
      cyc(0, 1, 4'b0000);
      if (restore_en !== 1'b1 || restore_flags !== exp_v) begin $display("FAIL ovf_pop%0d got=%b/%b exp=1/%b", i, restore_en, restore_flags, exp_v); n_fail++; end n_cmp++;
    end
    if (empty !== 1'b1 || ovf_err !== 1'b1) begin $display("FAIL ovf_sticky got=%b/%b exp=1/1", empty, ovf_err); n_fail++; end n_cmp++;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    if (ovf_err !== 1'b0) begin $display("FAIL ovf_clr got=%b exp=0", ovf_err); n_fail++; end n_cmp++;
  endtask

  task automatic test_underflow();
    cyc(0, 1, 4'b0000);
    if (restore_en !== 1'b0 || restore_flags !== 4'b0001) begin $display("FAIL unf_hold got=%b/%b exp=0/0001", restore_en, restore_flags); n_fail++; end n_cmp++;
    if (unf_err !== 1'b1 || level !== 3'd0) begin $display("FAIL unf_flag got=%b/%0d exp=1/0", unf_err, level); n_fail++; end n_cmp++;
    err_clr = 1'b1;
    tick();
    if (unf_err !== 1'b0) begin $display("FAIL unf_clr got=%b exp=0", unf_err); n_fail++; end n_cmp++;
    pop = 1'b1;
    tick();
    pop = 1'b0;
    if (unf_err !== 1'b1) begin $display("FAIL unf_set_wins got=%b exp=1", unf_err); n_fail++; end n_cmp++;
    tick();
    err_clr = 1'b0;
    if (unf_err !== 1'b0) begin $display("FAIL unf_clr2 got=%b exp=0", unf_err); n_fail++; end n_cmp++;
  endtask

  task automatic test_same_cycle();
    cyc(1, 0, 4'b0110);
    cyc(1, 0, 4'b0011);
    cyc(1, 1, 4'b1100);
    if (restore_en !== 1'b1 || restore_flags !== 4'b0011) begin $display("FAIL sc_restore got=%b/%b exp=1/0011", restore_en, restore_flags); n_fail++; end n_cmp++;
    if (level !== 3'd2) begin $display("FAIL sc_level got=%0d exp=2", level); n_fail++; end n_cmp++;
    cyc(0, 1, 4'b0000);
    if (restore_flags !== 4'b1100 || level !== 3'd1) begin $display("FAIL sc_replaced got=%b/%0d exp=1100/1", restore_flags, level); n_fail++; end n_cmp++;
    cyc(1, 0, 4'b0001);
    cyc(1, 0, 4'b0010);
    cyc(1, 0, 4'b0011);
    cyc(1, 1, 4'b1000);
    if (restore_flags !== 4'b0011 || level !== 3'd4 || ovf_err !== 1'b0) begin $display("FAIL sc_full got=%b/%0d/%b exp=0011/4/0", restore_flags, level, ovf_err); n_fail++; end n_cmp++;
    cyc(0, 1, 4'b0000);
    if (restore_flags !== 4'b1000) begin $display("FAIL sc_full_top got=%b exp=1000", restore_flags); n_fail++; end n_cmp++;
    cyc(0, 1, 4'b0000);
    cyc(0, 1, 4'b0000);
    cyc(0, 1, 4'b0000);
    if (restore_flags !== 4'b0110 || empty !== 1'b1) begin $display("FAIL sc_bottom got=%b/%b exp=0110/1", restore_flags, empty); n_fail++; end n_cmp++;
    cyc(1, 1, 4'b0101);
    if (level !== 3'd1 || restore_en !== 1'b0 || unf_err !== 1'b1 || restore_flags !== 4'b0110) begin
      $display("FAIL sc_empty got=%0d/%b/%b/%b exp=1/0/1/0110", level, restore_en, unf_err, restore_flags); n_fail++;
    end n_cmp++;
    cyc(0, 1, 4'b0000);
    if (restore_en !== 1'b1 || restore_flags !== 4'b0101 || level !== 3'd0) begin $display("FAIL sc_empty_pop got=%b/%b/%0d exp=1/0101/0", restore_en, restore_flags, level); n_fail++; end n_cmp++;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_v;
    cyc(1, 0, 4'b1001);
    cyc(1, 0, 4'b1110);
    cyc(1, 0, 4'b0111);
    pop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_v = (i == 0) ? 4'b0111 : (i == 1) ? 4'b1110 : 4'b1001;
      if (restore_en !== 1'b1 || restore_flags !== exp_v) begin $display("FAIL b2b_pop%0d got=%b/%b exp=1/%b", i, restore_en, restore_flags, exp_v); n_fail++; end n_cmp++;
    end
    pop = 1'b0;
    tick();
    if (restore_en !== 1'b0 || level !== 3'd0) begin $display("FAIL b2b_end got=%b/%0d exp=0/0", restore_en, level); n_fail++; end n_cmp++;
  endtask

`ifdef CCR_STACK_PARITY_EN
  task automatic test_parity();
    par_inject = 1'b1;
    cyc(1, 0, 4'b0111);
    par_inject = 1'b0;
    if (par_err !== 1'b0) begin $display("FAIL par_early got=%b exp=0", par_err); n_fail++; end n_cmp++;
    cyc(0, 1, 4'b0000);
    if (restore_flags !== 4'b0111 || restore_en !== 1'b1 || par_err !== 1'b1) begin $display("FAIL par_bad got=%b/%b/%b exp=0111/1/1", restore_flags, restore_en, par_err); n_fail++; end n_cmp++;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    if (par_err !== 1'b0) begin $display("FAIL par_clr got=%b exp=0", par_err); n_fail++; end n_cmp++;
    cyc(1, 0, 4'b0111);
    cyc(0, 1, 4'b0000);
    if (restore_flags !== 4'b0111 || par_err !== 1'b0) begin $display("FAIL par_clean got=%b/%b exp=0111/0", restore_flags, par_err); n_fail++; end n_cmp++;
  endtask
`endif

  task automatic test_reset_mid();
    cyc(1, 0, 4'b1001);
    cyc(1, 0, 4'b0110);
    cyc(0, 1, 4'b0000);
    cyc(0, 1, 4'b0000);
    pop = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    if (level !== 3'd0 || restore_flags !== 4'b0000 || empty !== 1'b1) begin $display("FAIL mid_async got=%0d/%b/%b exp=0/0000/1", level, restore_flags, empty); n_fail++; end n_cmp++;
    tick();
    pop = 1'b0;
    if (restore_en !== 1'b0 || unf_err !== 1'b0 || ovf_err !== 1'b0) begin $display("FAIL mid_cancel got=%b/%b/%b exp=0/0/0", restore_en, unf_err, ovf_err); n_fail++; end n_cmp++;
    rst = 1'b0;
    tick();
    cyc(1, 0, 4'b0011);
    cyc(0, 1, 4'b0000);
    if (restore_en !== 1'b1 || restore_flags !== 4'b0011) begin $display("FAIL mid_recover got=%b/%b exp=1/0011", restore_en, restore_flags); n_fail++; end n_cmp++;
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_same_cycle();
    test_back_to_back();
`ifdef CCR_STACK_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_ccr_save_stack
`default_nettype wire
